// File: rtl/jt053246_dmactl.sv
// Object-RAM DMA sequencer: copies the sprite table from CPU-side RAM into the even/odd scan RAMs.
// Optional build macro JT053246_DMA_SKIP_EN skips words 1-7 of objects whose word 0 has bit15 clear.
module jt053246_dmactl #(
   parameter int unsigned OBJ46 = 256,
   parameter int unsigned OBJ44 = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pxl2_cen,
   input  logic         k44_en,
   input  logic         dma_en,
   input  logic         dma_trig,
   input  logic         vs,
   output logic [13:1]  dma_addr,
   input  logic [15:0]  dma_data,
   output logic         dma_bsy,
   output logic [11:1]  dma_wr_addr,
   output logic [15:0]  dma_din,
   output logic         dma_wel,
   output logic         dma_weh,
   output logic         flicker
);

   localparam logic [13:1] Words46 = 13'(8 * OBJ46);
   localparam logic [13:1] Words44 = 13'(8 * OBJ44);

   typedef enum logic [1:0] {StIdle, StRead, StCopy} state_e;

   state_e      st_q;
   logic        vs_q, pend_q, k44_q, wr_pend_q, bsy_q, flick_q;
   logic [13:1] addr_q, addr_d;
   logic [11:1] wr_addr_q;
   logic [15:0] din_q;
   logic        start, last, capture;

   assign start   = k44_en ? dma_trig : (vs & ~vs_q & dma_en);
   // The read address doubles as the word counter: it reaches N once every word is captured.
   assign last    = addr_q == (k44_q ? Words44 : Words46);
   assign capture = pxl2_cen & ((st_q == StRead) | ((st_q == StCopy) & ~last));

`ifdef JT053246_DMA_SKIP_EN
   // A disabled object (word 0 bit15 low) jumps straight to the next object base.
   always_comb begin
      addr_d = addr_q + 13'd1;
      if (addr_q[3:1] == 3'd0 && !dma_data[15]) addr_d = addr_q + 13'd8;
   end
`else
   assign addr_d = addr_q + 13'd1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= StIdle;
         vs_q      <= 1'b0;
         pend_q    <= 1'b0;
         k44_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         bsy_q     <= 1'b0;
         flick_q   <= 1'b0;
         addr_q    <= '0;
         wr_addr_q <= '0;
         din_q     <= '0;
      end else begin
         vs_q <= vs;
         if (capture) begin
            din_q     <= dma_data;
            wr_addr_q <= addr_q[11:1];
            addr_q    <= addr_d;
            wr_pend_q <= 1'b1;
         end
         case (st_q)
            StIdle: begin
               if (pxl2_cen) begin
                  if (start || pend_q) begin
                     st_q   <= StRead;
                     addr_q <= '0;
                     bsy_q  <= 1'b1;
                     k44_q  <= k44_en;
                     pend_q <= 1'b0;
                  end
               end else if (start) begin
                  pend_q <= 1'b1;
               end
            end
            StRead: begin
               if (pxl2_cen) st_q <= StCopy;
            end
            StCopy: begin
               // Final tick only flushes the last captured word.
               if (pxl2_cen && last) begin
                  st_q      <= StIdle;
                  bsy_q     <= 1'b0;
                  wr_pend_q <= 1'b0;
                  flick_q   <= ~flick_q;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign dma_addr    = addr_q;
   assign dma_bsy     = bsy_q;
   assign dma_wr_addr = wr_addr_q;
   assign dma_din     = din_q;
   assign flicker     = flick_q;
   assign dma_wel     = pxl2_cen & wr_pend_q & ~wr_addr_q[1];
   assign dma_weh     = pxl2_cen & wr_pend_q & wr_addr_q[1];

endmodule

// File: tb/tb_jt053246_dmactl.sv
// Bench for jt053246_dmactl: transaction-level word-list model checked every cycle, plus directed
// scenarios with literal expectations. Honours JT053246_DMA_SKIP_EN when the build defines it.
module tb_jt053246_dmactl;

   logic        clk = 1'b0, rst_n = 1'b0, pxl2_cen = 1'b0;
   logic        k44_en = 1'b0, dma_en = 1'b0, dma_trig = 1'b0, vs = 1'b0;
   logic [13:1] dma_addr;
   logic [15:0] dma_data;
   logic        dma_bsy;
   logic [11:1] dma_wr_addr;
   logic [15:0] dma_din;
   logic        dma_wel, dma_weh, flicker;

   logic [15:0] ext_ram [0:8191];
   logic [15:0] scan    [0:2047];

   int n_cmp = 0, n_err = 0;
   int wr_cnt = 0, odd_cnt = 0, bsy_ticks = 0;

`ifdef JT053246_DMA_SKIP_EN
   localparam int Wr46 = 256, Wr44 = 128, Odd44 = 0, RstAt = 100, TrigReps = 1, Wr46Obj3 = 263;
`else
   localparam int Wr46 = 2048, Wr44 = 1024, Odd44 = 512, RstAt = 500, TrigReps = 9, Wr46Obj3 = 2048;
`endif

   jt053246_dmactl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pxl2_cen    (pxl2_cen),
      .k44_en      (k44_en),
      .dma_en      (dma_en),
      .dma_trig    (dma_trig),
      .vs          (vs),
      .dma_addr    (dma_addr),
      .dma_data    (dma_data),
      .dma_bsy     (dma_bsy),
      .dma_wr_addr (dma_wr_addr),
      .dma_din     (dma_din),
      .dma_wel     (dma_wel),
      .dma_weh     (dma_weh),
      .flicker     (flicker)
   );

   always #5 clk = ~clk;
   assign dma_data = ext_ram[dma_addr];

   // Enable pattern 0,1,1 repeating: gives back-to-back ticks and idle gaps.
   int cen_ph = 0;
   always @(posedge clk) begin
      #1;
      cen_ph++;
      pxl2_cen = (cen_ph % 3 != 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a transfer is the ordered list of word addresses to copy; tick t after start
   // captures word t-1, which is written during tick t+1; the transfer ends at tick len+1.
   bit          m_active = 1'b0, m_pend = 1'b0, m_vsp = 1'b0, m_flick = 1'b0;
   int          m_t = 0, m_len = 0, m_n = 0;
   logic [13:1] m_addr = '0;
   int          m_words[$];

   function automatic void build(input logic k44);
      m_n = k44 ? 1024 : 2048;
      m_words.delete();
      for (int o = 0; o < m_n / 8; o++) begin
         m_words.push_back(o * 8);
`ifdef JT053246_DMA_SKIP_EN
         if (ext_ram[o*8][15])
`endif
         for (int k = 1; k < 8; k++) m_words.push_back(o * 8 + k);
      end
      m_len = m_words.size();
   endfunction

   function automatic void model_advance();
      logic st;
      st = k44_en ? dma_trig : (vs && !m_vsp && dma_en);
      if (!m_active) begin
         if (pxl2_cen) begin
            if (st || m_pend) begin
               m_active = 1'b1;
               m_t      = 0;
               m_pend   = 1'b0;
               m_addr   = '0;
               build(k44_en);
            end
         end else if (st) begin
            m_pend = 1'b1;
         end
      end else if (pxl2_cen) begin
         m_t++;
         if (m_t == m_len + 1) begin
            m_active = 1'b0;
            m_flick  = ~m_flick;
         end else begin
            m_addr = (m_t < m_len) ? 13'(m_words[m_t]) : 13'(m_n);
         end
      end
      m_vsp = vs;
   endfunction

   always @(negedge clk) begin
      int w;
      if (!rst_n) begin
         m_active = 1'b0;
         m_pend   = 1'b0;
         m_vsp    = 1'b0;
         m_flick  = 1'b0;
         m_addr   = '0;
      end
      chk("bsy", dma_bsy, m_active);
      chk("addr", dma_addr, m_addr);
      chk("flicker", flicker, m_flick);
      if (pxl2_cen && m_active && m_t >= 1) begin
         w = m_words[m_t-1];
         chk("wel", dma_wel, w % 2 == 0);
         chk("weh", dma_weh, w % 2 == 1);
         chk("wr_addr", dma_wr_addr, w);
         chk("din", dma_din, ext_ram[w]);
      end else begin
         chk("we_idle", {dma_wel, dma_weh}, 0);
      end
      if (dma_wel || dma_weh) begin
         scan[dma_wr_addr] = dma_din;
         wr_cnt++;
         if (dma_weh) odd_cnt++;
      end
      if (pxl2_cen && dma_bsy) bsy_ticks++;
      if (rst_n) model_advance();
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr_stats();
      wr_cnt    = 0;
      odd_cnt   = 0;
      bsy_ticks = 0;
      for (int i = 0; i < 2048; i++) scan[i] = 16'hdead;
   endtask

   task automatic wait_done(input string nm);
      int c = 0;
      while (!dma_bsy && c < 40) begin step(); c++; end
      while (dma_bsy && c < 6000) begin step(); c++; end
      chk({nm, "_timeout"}, c < 6000, 1);
   endtask

   task automatic trig_pulse();
      dma_trig = 1'b1;
      step();
      dma_trig = 1'b0;
   endtask

   initial begin
      int c;
      for (int i = 0; i < 8192; i++) ext_ram[i] = 16'(i);
      clr_stats();
      step(3);
      chk("rst_bsy", dma_bsy, 0);
      chk("rst_addr", dma_addr, 0);
      chk("rst_wr_addr", dma_wr_addr, 0);
      chk("rst_din", dma_din, 0);
      chk("rst_we", {dma_wel, dma_weh}, 0);
      chk("rst_flicker", flicker, 0);
      rst_n = 1'b1;
      step(2);

      // k46 VS-triggered copy; dma_en drops mid-transfer without aborting it.
      dma_en = 1'b1;
      vs = 1'b1;
      step(3);
      vs = 1'b0;
      step(500);
      dma_en = 1'b0;
      wait_done("k46");
      chk("k46_writes", wr_cnt, Wr46);
      chk("k46_bsy_ticks", bsy_ticks, Wr46 + 1);
      chk("k46_scan0", scan[0], 16'h0000);
      chk("k46_scan2040", scan[2040], 16'd2040);
`ifndef JT053246_DMA_SKIP_EN
      chk("k46_scan1", scan[1], 16'h0001);
      chk("k46_scan2047", scan[2047], 16'd2047);
`endif
      chk("k46_flicker", flicker, 1);
      chk("k46_addr_end", dma_addr, 2048);

      // k44 trigger on a non-tick clock (pending path); mode flips mid-transfer.
      clr_stats();
      k44_en = 1'b1;
      c = 0;
      while (pxl2_cen && c < 5) begin step(); c++; end
      trig_pulse();
      step(450);
      k44_en = 1'b0;
      wait_done("k44");
      chk("k44_writes", wr_cnt, Wr44);
      chk("k44_odd", odd_cnt, Odd44);
      chk("k44_bsy_ticks", bsy_ticks, Wr44 + 1);
      chk("k44_flicker", flicker, 0);
      chk("k44_addr_end", dma_addr, 1024);

      // Repeated triggers while busy must not restart; vs edge alongside is not a k44 start.
      clr_stats();
      k44_en = 1'b1;
      dma_en = 1'b1;
      vs = 1'b1;
      trig_pulse();
      vs = 1'b0;
      for (int k = 0; k < TrigReps; k++) begin
         step(150);
         trig_pulse();
      end
      wait_done("retrig");
      chk("retrig_writes", wr_cnt, Wr44);
      chk("retrig_flicker", flicker, 1);
      step(10);
      chk("retrig_no_restart", dma_bsy, 0);

      // k46 start with simultaneous trig, then reset mid-transfer.
      clr_stats();
      k44_en = 1'b0;
      vs = 1'b1;
      dma_trig = 1'b1;
      step();
      vs = 1'b0;
      dma_trig = 1'b0;
      c = 0;
      while (wr_cnt < RstAt && c < 4000) begin step(); c++; end
      chk("rst_reach", wr_cnt, RstAt);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_bsy", dma_bsy, 0);
      chk("rst_mid_we", {dma_wel, dma_weh}, 0);
      step(4);
      rst_n = 1'b1;
      step(20);
      chk("rst_no_writes", wr_cnt, RstAt);
      chk("rst_addr0", dma_addr, 0);
      chk("rst_flick0", flicker, 0);
      clr_stats();
      vs = 1'b1;
      step(2);
      vs = 1'b0;
      wait_done("restart");
      chk("restart_writes", wr_cnt, Wr46);
      chk("restart_scan0", scan[0], 16'h0000);

      // dma_en low: vs edge does nothing.
      clr_stats();
      dma_en = 1'b0;
      vs = 1'b1;
      step(3);
      vs = 1'b0;
      step(60);
      chk("noen_writes", wr_cnt, 0);
      chk("noen_bsy", dma_bsy, 0);
      chk("noen_ticks", bsy_ticks, 0);

      // Only object 3 enabled.
      clr_stats();
      ext_ram[24] = 16'h8018;
      dma_en = 1'b1;
      vs = 1'b1;
      step(2);
      vs = 1'b0;
      wait_done("obj3");
      chk("obj3_writes", wr_cnt, Wr46Obj3);
      chk("obj3_w24", scan[24], 16'h8018);
      chk("obj3_w31", scan[31], 16'd31);
      chk("obj3_w32", scan[32], 16'd32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
